// File: rtl/wb_trace_buffer.sv
// Circular trace buffer of (PC, WriteBack) pairs. It records one entry each time the observed
// PC changes, and the stored entries are drained in capture order through a registered pop port.
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DROPW = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      PC,
    input  logic [31:0]      WriteBack,
    input  logic             Capture_En,
    input  logic             Rd_En,
    output logic             Rd_Valid,
    output logic [31:0]      Rd_PC,
    output logic [31:0]      Rd_WB,
    output logic [AW:0]      Count,
    output logic             Full,
    output logic             Empty,
    output logic             Overflow,
    output logic [DROPW-1:0] Drop_Count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [31:0]   last_pc;
    logic          primed;

    logic cap;
    logic rd_ok;
    logic wr_ok;
    logic drop;

    assign Full  = (Count == DEPTH_C);
    assign Empty = (Count == '0);

    // Read handshake: Rd_En is a request. It is accepted when the buffer is not empty, and the
    // popped pair shows up on Rd_PC/Rd_WB with Rd_Valid=1 on the next cycle. There is no ready
    // signal back to the reader, and a request made while the buffer is empty is ignored.
    assign cap   = Capture_En && (!primed || (PC != last_pc));
    assign rd_ok = Rd_En && !Empty;
    assign wr_ok = cap && (!Full || rd_ok);
    assign drop  = cap && !wr_ok;

    // Storage carries no reset; entries are qualified only by the pointers and Count.
    always_ff @(posedge Clk) begin
        if (!Reset && wr_ok) begin
            mem[wptr] <= {PC, WriteBack};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr       <= '0;
            rptr       <= '0;
            last_pc    <= '0;
            primed     <= 1'b0;
            Count      <= '0;
            Rd_Valid   <= 1'b0;
            Rd_PC      <= '0;
            Rd_WB      <= '0;
            Overflow   <= 1'b0;
            Drop_Count <= '0;
        end else begin
            if (cap) begin
                last_pc <= PC;
                primed  <= 1'b1;
            end
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            Rd_Valid <= rd_ok;
            if (rd_ok) begin
                rptr  <= rptr + 1'b1;
                Rd_PC <= mem[rptr][63:32];
                Rd_WB <= mem[rptr][31:0];
            end
            if (drop) begin
                Overflow <= 1'b1;
                if (Drop_Count != '1) begin
                    Drop_Count <= Drop_Count + 1'b1;
                end
            end
            case ({wr_ok, rd_ok})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer. A queue models the stored entries: an entry is pushed when a
// sample should be accepted, and it is popped and compared when the DUT presents it.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DROPW = 8;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [31:0]      PC = '0;
    logic [31:0]      WriteBack = '0;
    logic             Capture_En = 1'b0;
    logic             Rd_En = 1'b0;
    logic             Rd_Valid;
    logic [31:0]      Rd_PC;
    logic [31:0]      Rd_WB;
    logic [AW:0]      Count;
    logic             Full;
    logic             Empty;
    logic             Overflow;
    logic [DROPW-1:0] Drop_Count;

    wb_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .DROPW(DROPW)) dut (
        .Clk(Clk), .Reset(Reset), .PC(PC), .WriteBack(WriteBack),
        .Capture_En(Capture_En), .Rd_En(Rd_En), .Rd_Valid(Rd_Valid),
        .Rd_PC(Rd_PC), .Rd_WB(Rd_WB), .Count(Count), .Full(Full),
        .Empty(Empty), .Overflow(Overflow), .Drop_Count(Drop_Count)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_last;
    logic        m_primed;
    logic        m_ovf;
    logic [7:0]  m_drop;
    logic        m_valid;
    logic [63:0] m_rd;
    int          max_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("rd_valid", 64'(Rd_Valid), 64'(m_valid));
        check("rd_pc", 64'(Rd_PC), 64'(m_rd[63:32]));
        check("rd_wb", 64'(Rd_WB), 64'(m_rd[31:0]));
        check("count", 64'(Count), 64'(exp_q.size()));
        check("full", 64'(Full), 64'(exp_q.size() == DEPTH));
        check("empty", 64'(Empty), 64'(exp_q.size() == 0));
        check("overflow", 64'(Overflow), 64'(m_ovf));
        check("drop_count", 64'(Drop_Count), 64'(m_drop));
        if (int'(Count) > max_count) max_count = int'(Count);
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_last   = '0;
        m_primed = 1'b0;
        m_ovf    = 1'b0;
        m_drop   = '0;
        m_valid  = 1'b0;
        m_rd     = '0;
    endtask

    // driver: one reset cycle, optionally with a pending read request
    task automatic reset_cycle(input logic rd);
        Reset = 1'b1; Rd_En = rd; Capture_En = 1'b0;
        @(posedge Clk);
        model_clear();
        #1;
        check_outputs();
        Reset = 1'b0;
    endtask

    // driver: one functional cycle plus its expected effect
    task automatic step(input logic ce, input logic [31:0] pc, input logic [31:0] wb, input logic rd);
        logic cap, rd_ok, wr_ok;
        Capture_En = ce; PC = pc; WriteBack = wb; Rd_En = rd;
        cap   = ce && (!m_primed || pc != m_last);
        rd_ok = rd && (exp_q.size() != 0);
        wr_ok = cap && ((exp_q.size() < DEPTH) || rd_ok);
        @(posedge Clk);
        if (cap) begin
            m_last = pc;
            m_primed = 1'b1;
        end
        if (cap && !wr_ok) begin
            m_ovf = 1'b1;
            if (m_drop != 8'hff) m_drop = m_drop + 8'd1;
        end
        m_valid = rd_ok;
        if (rd_ok) m_rd = exp_q.pop_front();
        if (wr_ok) exp_q.push_back({pc, wb});
        #1;
        check_outputs();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0);
        check("drained_empty", 64'(Empty), 64'd1);
    endtask

    initial begin
        logic [31:0] pcs [5];
        logic [31:0] wbs [5];
        pcs = '{32'h00, 32'h04, 32'h04, 32'h04, 32'h08};
        wbs = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        max_count = 0;

        // 1: reset, then idle
        reset_cycle(1'b0);
        reset_cycle(1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'($urandom), 32'($urandom), 1'b0);
        check("t1_count", 64'(Count), 64'd0);
        check("t1_empty", 64'(Empty), 64'd1);
        check("t1_rd_pc", 64'(Rd_PC), 64'd0);

        // 2: stalls collapse to one entry
        for (int i = 0; i < 5; i++) step(1'b1, pcs[i], wbs[i], 1'b0);
        check("t2_count", 64'(Count), 64'd3);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        check("t2_pop0", {Rd_PC, Rd_WB}, {32'h00, 32'h11});
        step(1'b0, 32'h0, 32'h0, 1'b1);
        check("t2_pop1", {Rd_PC, Rd_WB}, {32'h04, 32'h22});
        step(1'b0, 32'h0, 32'h0, 1'b1);
        check("t2_pop2", {Rd_PC, Rd_WB}, {32'h08, 32'h55});
        step(1'b0, 32'h0, 32'h0, 1'b1);
        check("t2_pop3_invalid", 64'(Rd_Valid), 64'd0);

        // 3: overflow
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 32'(i * 4), $urandom, 1'b0);
            if (i == 15) check("t3_full16", 64'(Full), 64'd1);
        end
        check("t3_overflow", 64'(Overflow), 64'd1);
        check("t3_drop2", 64'(Drop_Count), 64'd2);
        drain();
        check("t3_last_pc", 64'(Rd_PC), 64'h3c);

        // 4: write into a full buffer while popping
        reset_cycle(1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h200 + 32'(i * 4), $urandom, 1'b0);
        step(1'b1, 32'h100, 32'hcafe, 1'b1);
        check("t4_count16", 64'(Count), 64'd16);
        check("t4_no_ovf", 64'(Overflow), 64'd0);
        check("t4_oldest", 64'(Rd_PC), 64'h200);
        drain();
        check("t4_last_pc", 64'(Rd_PC), 64'h100);

        // 5: wrap with interleaved pops
        max_count = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 32'h1000 + 32'(i * 4), $urandom, i[0]);
        drain();
        check("t5_max_count", 64'(max_count <= DEPTH), 64'd1);

        // 6: reset during a pending read, then PC=0 is captured
        for (int i = 0; i < 5; i++) step(1'b1, 32'h3000 + 32'(i * 4), $urandom, 1'b0);
        reset_cycle(1'b1);
        check("t6_count0", 64'(Count), 64'd0);
        check("t6_valid0", 64'(Rd_Valid), 64'd0);
        step(1'b1, 32'h0, 32'hab, 1'b0);
        check("t6_pc0_captured", 64'(Count), 64'd1);
        drain();
        check("t6_pop", {Rd_PC, Rd_WB}, {32'h0, 32'hab});

        // random mix
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4), $urandom, 1'($urandom_range(0, 1)));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
